// File: rtl/alu_slice_sequencer.sv
// Multi-cycle ADD/SUB/AND/XOR unit that walks one SLICE-bit datapath across a
// WIDTH-bit operand pair, LSB slice first, then returns the result with Y86 condition codes.
//
// state | meaning
// IDLE  | ready for a request; last response stays on rsp_result and the flags
// RUN   | one slice per cycle, carry and zero accumulator threaded between slices
// DONE  | rsp_valid high and held until rsp_ready
module alu_slice_sequencer #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_cf,
  output logic             rsp_zf,
  output logic             rsp_sf,
  output logic             rsp_of,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0]    LAST = CW'(NSLICE - 1);
  localparam logic [WIDTH-1:0] MASK = WIDTH'({SLICE{1'b1}});

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt_q;
  logic [1:0]        op_q;
  logic [WIDTH-1:0]  a_q, b_q, res_q;
  logic              carry_q, zacc_q;

  logic [31:0]       sh;
  logic [SLICE-1:0]  a_k, b_k, b_eff, slice_val;
  logic [SLICE:0]    sum;
  logic              is_arith, carry_nxt, zacc_nxt, of_nxt, r_msb;
  logic [WIDTH-1:0]  res_nxt;

  // Slice datapath; res_nxt is the working result with the current slice merged in.
  always_comb begin
    sh        = 32'(cnt_q) * SLICE;
    a_k       = SLICE'(a_q >> sh);
    b_k       = SLICE'(b_q >> sh);
    is_arith  = ~op_q[1];
    b_eff     = (op_q == OP_SUB) ? ~b_k : b_k;
    sum       = {1'b0, a_k} + {1'b0, b_eff} + (SLICE+1)'(carry_q);
    case (op_q)
      OP_AND:  slice_val = a_k & b_k;
      OP_XOR:  slice_val = a_k ^ b_k;
      default: slice_val = sum[SLICE-1:0];
    endcase
    carry_nxt = is_arith ? sum[SLICE] : carry_q;
    zacc_nxt  = zacc_q & (slice_val == '0);
    res_nxt   = (res_q & ~(MASK << sh)) | (WIDTH'(slice_val) << sh);
    r_msb     = res_nxt[WIDTH-1];
    case (op_q)
      OP_ADD:  of_nxt = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (r_msb != a_q[WIDTH-1]);
      OP_SUB:  of_nxt = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (r_msb != a_q[WIDTH-1]);
      default: of_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt_q      <= '0;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      zacc_q     <= 1'b0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
      rsp_result <= '0;
      rsp_cf     <= 1'b0;
      rsp_zf     <= 1'b0;
      rsp_sf     <= 1'b0;
      rsp_of     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_q      <= req_op;
            a_q       <= req_a;
            b_q       <= req_b;
            res_q     <= '0;
            carry_q   <= (req_op == OP_SUB);
            zacc_q    <= 1'b1;
            cnt_q     <= '0;
            state     <= RUN;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          res_q   <= res_nxt;
          carry_q <= carry_nxt;
          zacc_q  <= zacc_nxt;
          if (cnt_q == LAST) begin
            // Response registers load only here so they survive the next accept.
            state      <= DONE;
            rsp_valid  <= 1'b1;
            rsp_result <= res_nxt;
            rsp_cf     <= is_arith & carry_nxt;
            rsp_zf     <= zacc_nxt;
            rsp_sf     <= r_msb;
            rsp_of     <= of_nxt;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Directed bench for alu_slice_sequencer at default WIDTH=64, SLICE=16.
module tb_alu_slice_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [63:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_result;
  logic        rsp_cf, rsp_zf, rsp_sf, rsp_of, busy;

  int n_vec = 0;
  int n_err = 0;

  alu_slice_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cf(rsp_cf), .rsp_zf(rsp_zf), .rsp_sf(rsp_sf), .rsp_of(rsp_of),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic cf, input logic zf,
                           input logic sf, input logic of);
    chk({tag, "/cf"}, 64'(rsp_cf), 64'(cf));
    chk({tag, "/zf"}, 64'(rsp_zf), 64'(zf));
    chk({tag, "/sf"}, 64'(rsp_sf), 64'(sf));
    chk({tag, "/of"}, 64'(rsp_of), 64'(of));
  endtask

  // Starts and ends at a negedge. hold=1 keeps rsp_ready low for 3 DONE cycles
  // while offering a competing request that must be ignored.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] r, input logic cf,
                        input logic zf, input logic sf, input logic of, input bit hold);
    int k;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_op = 2'b11; req_a = '1; req_b = '0;
    chk({tag, "/busy_run"}, 64'(busy), 64'd1);
    chk({tag, "/rdy_run"}, 64'(req_ready), 64'd0);
    k = 0;
    while (!rsp_valid && k < 12) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "/latency"}, 64'(k), 64'd4);
    chk({tag, "/result"}, rsp_result, r);
    chk_flags(tag, cf, zf, sf, of);
    chk({tag, "/rdy_done"}, 64'(req_ready), 64'd0);
    if (hold) begin
      req_valid = 1'b1; req_op = 2'b00; req_a = 64'h1111; req_b = 64'h2222;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk({tag, "/hold_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "/hold_result"}, rsp_result, r);
        chk({tag, "/hold_rdy"}, 64'(req_ready), 64'd0);
        chk_flags({tag, "/hold"}, cf, zf, sf, of);
      end
      req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "/valid_drop"}, 64'(rsp_valid), 64'd0);
    chk({tag, "/rdy_idle"}, 64'(req_ready), 64'd1);
    chk({tag, "/busy_idle"}, 64'(busy), 64'd0);
    chk({tag, "/result_kept"}, rsp_result, r);
    if (hold) begin
      @(negedge clk);
      chk({tag, "/no_reaccept"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset/rdy", 64'(req_ready), 64'd1);
    chk("reset/valid", 64'(rsp_valid), 64'd0);
    chk("reset/busy", 64'(busy), 64'd0);
    chk("reset/result", rsp_result, 64'd0);
    chk_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);

    //          tag            op     A                      B                      result                 cf    zf    sf    of
    run_op("sub5m3",    2'b01, 64'd5,                 64'd3,                 64'd2,                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sub3m5",    2'b01, 64'd3,                 64'd5,                 64'hFFFFFFFFFFFFFFFE,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("sub_minm1", 2'b01, 64'h8000000000000000,  64'd1,                 64'h7FFFFFFFFFFFFFFF,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("add_carry", 2'b00, 64'h000000000000FFFF,  64'd1,                 64'h0000000000010000,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("add_wrap",  2'b00, 64'hFFFFFFFFFFFFFFFF,  64'd1,                 64'd0,                 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("xor_same",  2'b11, 64'h123456789ABCDEF0,  64'h123456789ABCDEF0,  64'd0,                 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("and_mask",  2'b10, 64'hF0F0F0F0F0F0F0F0,  64'hFFFFFFFFFFFFFFFF,  64'hF0F0F0F0F0F0F0F0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("add_ovf",   2'b00, 64'h7FFFFFFFFFFFFFFF,  64'd1,                 64'h8000000000000000,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Reset during the second RUN cycle of a SUB abandons it.
    req_valid = 1'b1; req_op = 2'b01; req_a = 64'd100; req_b = 64'd1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst/rdy", 64'(req_ready), 64'd1);
    chk("midrst/valid", 64'(rsp_valid), 64'd0);
    chk("midrst/busy", 64'(busy), 64'd0);
    chk("midrst/result", rsp_result, 64'd0);
    chk_flags("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst/no_rsp", 64'(rsp_valid), 64'd0);
    end

    run_op("after_rst", 2'b00, 64'h0000000100000000, 64'h00000000FFFFFFFF, 64'h00000001FFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_slice_sequencer.md
Name: alu_slice_sequencer

Overview:
- Multi-cycle controller that sequences one narrow SLICE-bit adder/subtractor slice across a WIDTH-bit operand pair, LSB slice first, carrying between slices.
- Used in the execute stage as the area-reduced alternative to the full-width ripple subtractor.
- Operations: ADD, SUB (A - B computed as A + ~B + 1), AND and XOR.
- Produces the result and Y86 condition codes through valid/ready handshakes on both the request and response sides.

Parameters:
- WIDTH, 64, operand and result width in bits.
- SLICE, 16, bits processed per cycle. WIDTH must be an integer multiple of SLICE; NSLICE = WIDTH/SLICE is derived.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_op  input  2  operation: 00 ADD, 01 SUB, 10 AND, 11 XOR.
- req_a  input  WIDTH  operand A.
- req_b  input  WIDTH  operand B.
- rsp_valid  output  1  result and flags valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  WIDTH  operation result.
- rsp_cf  output  1  raw carry-out of the MSB slice (ADD/SUB only).
- rsp_zf  output  1  result == 0.
- rsp_sf  output  1  result MSB.
- rsp_of  output  1  signed overflow (ADD/SUB only).
- busy  output  1  high in RUN or DONE.

Behaviour:
Reset:
- Synchronous, active-high: state=IDLE, slice counter=0.
- rsp_valid=0, rsp_result=0, all flags=0, req_ready=1, busy=0.
- Reset asserted in any state, including mid-RUN, abandons the operation.
- No response is produced for an abandoned request.

States:
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch op, A, B; clear the result register; set carry to 1 for SUB, 0 otherwise; set the zero accumulator to 1; go to RUN with counter=0.
- RUN:
  - req_ready=0. Each cycle processes slice k = counter, bits [k*SLICE +: SLICE].
  - ADD: a_k + b_k + carry. SUB: a_k + ~b_k + carry. AND/XOR: bitwise, carry unchanged.
  - Write the slice into the result register, update carry, and AND the zero accumulator with (slice==0).
  - At counter==NSLICE-1, go to DONE. Otherwise increment counter.
- DONE:
  - rsp_valid=1; outputs held stable while rsp_ready=0.
  - On rsp_ready, go to IDLE and drop rsp_valid. rsp_result and flags keep their last value until the next DONE.
  - req_ready=0 in DONE; there is no same-cycle re-accept.

Timing:
- Accept at edge T; slices complete at edges T+1..T+NSLICE.
- rsp_valid is first high in the cycle after edge T+NSLICE.
- Latency is NSLICE cycles (4 at defaults). Minimum issue interval is NSLICE+2 cycles.

Flags (registered, valid with rsp_valid):
- zf = zero accumulator. sf = result[WIDTH-1].
- cf = final carry for ADD/SUB, 0 for AND/XOR. For SUB, cf=1 means no borrow.
- of, ADD: a[MSB]==b[MSB] && r[MSB]!=a[MSB].
- of, SUB: a[MSB]!=b[MSB] && r[MSB]!=a[MSB].
- of, AND/XOR: 0.

Other rules:
- Operand and op inputs are ignored outside the accept cycle.
- Request signals in RUN/DONE are ignored, with no side effects.
- When SLICE==WIDTH, RUN lasts one cycle.
- All arithmetic wraps modulo 2^WIDTH.

Test Plan:
- SUB A=5, B=3 -> result 2; cf=1, zf=0, sf=0, of=0; rsp_valid exactly 4 cycles after accept.
- SUB A=3, B=5 -> result 0xFFFFFFFFFFFFFFFE; cf=0, sf=1, zf=0, of=0.
- SUB A=0x8000000000000000, B=1 -> result 0x7FFFFFFFFFFFFFFF; of=1, sf=0, cf=1.
- ADD A=0x000000000000FFFF, B=1 -> result 0x0000000000010000, confirming the inter-slice carry. Also ADD 0xFFFFFFFFFFFFFFFF+1 -> result 0, zf=1, cf=1.
- XOR A=B=0x123456789ABCDEF0 -> result 0, zf=1, cf=0, of=0. AND 0xF0F0...F0 with 0xFFFF...FF -> 0xF0F0...F0, sf=1.
- Hold rsp_ready=0 for 3 cycles in DONE -> outputs stable, req_ready=0, a second req_valid is ignored. Then assert rst in the 2nd RUN cycle of a new SUB -> next cycle IDLE, rsp_valid=0, all outputs 0, req_ready=1.
